pe_feeder: RTL and testbench

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/pe_feeder.sv | 237 +++++++++++++++++++++++
 tb/tb_pe_feeder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder.sv
// pe_feeder: streams filter, ifmap and ipsum words from the buffer to a PE
// and writes the PE's output partial sums back to the buffer.
module pe_feeder #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [12:0]          cfg,
  input  logic [ADDR_BITS-1:0] filter_base,
  input  logic [ADDR_BITS-1:0] ifmap_base,
  input  logic [ADDR_BITS-1:0] ipsum_base,
  input  logic [ADDR_BITS-1:0] opsum_base,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 pe_en,
  output logic [12:0]          pe_config,
  output logic [DATA_BITS-1:0] filter,
  output logic [DATA_BITS-1:0] ifmap,
  output logic [DATA_BITS-1:0] ipsum,
  output logic                 filter_valid,
  output logic                 ifmap_valid,
  output logic                 ipsum_valid,
  input  logic                 filter_ready,
  input  logic                 ifmap_ready,
  input  logic                 ipsum_ready,
  input  logic [DATA_BITS-1:0] opsum,
  input  logic                 opsum_valid,
  output logic                 opsum_ready
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_FILTER,
    SEND_IFMAP,
    SEND_IPSUM,
    RECV_OPSUM
  } state_t;

  state_t state, state_n;

  logic [12:0]          cfg_q;
  logic [ADDR_BITS-1:0] fb_q, ib_q, pb_q, ob_q;
  logic [4:0]           col, col_n;
  logic [4:0]           cnt, cnt_n;
  logic                 first, first_n;
  logic                 vld, vld_n;
  logic                 pe_en_q;

  logic [2:0] p, q, rs, n;
  logic [4:0] pxrs;
  logic [7:0] cn;
  logic [4:0] total;
  logic [4:0] idx;
  logic       rdy, hs, last;
  logic       accept;

  logic [ADDR_BITS-1:0] rd_base;
  logic [7:0]           rd_off;
  logic [7:0]           wr_off;

  assign p    = {1'b0, cfg_q[8:7]} + 3'd1;
  assign q    = {1'b0, cfg_q[1:0]} + 3'd1;
  assign rs   = {1'b0, cfg_q[11:10]} + 3'd1;
  assign n    = cfg_q[12] ? q : p;
  assign pxrs = {2'b0, p} * {2'b0, rs};
  assign cn   = {3'b0, col} * {5'b0, n};

  assign accept = (state == IDLE) && start;

  always_comb begin
    total = '0;
    rdy   = 1'b0;
    unique case (state)
      SEND_FILTER: begin
        total = pxrs;
        rdy   = filter_ready;
      end
      SEND_IFMAP: begin
        total = (col == 5'd0) ? {2'b0, rs} : 5'd1;
        rdy   = ifmap_ready;
      end
      SEND_IPSUM: begin
        total = {2'b0, n};
        rdy   = ipsum_ready;
      end
      RECV_OPSUM: total = {2'b0, n};
      default: ;
    endcase
  end

  assign hs   = (state == RECV_OPSUM) ? opsum_valid : (vld & rdy);
  assign last = (cnt + 5'd1) == total;
  // First word of a state reads offset 0; later reads prefetch cnt+1.
  assign idx  = first ? 5'd0 : cnt + 5'd1;

  always_comb begin
    rd_base = '0;
    rd_off  = '0;
    unique case (state)
      SEND_FILTER: begin
        rd_base = fb_q;
        rd_off  = {3'b0, idx};
      end
      SEND_IFMAP: begin
        rd_base = ib_q;
        rd_off  = (col == 5'd0) ? {3'b0, idx}
                : {5'b0, rs} - 8'd1 + {3'b0, col};
      end
      SEND_IPSUM: begin
        rd_base = pb_q;
        rd_off  = cn + {3'b0, idx};
      end
      default: ;
    endcase
  end

  assign wr_off = cn + {3'b0, cnt};

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    col_n       = col;
    first_n     = 1'b0;
    vld_n       = vld;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    done        = 1'b0;
    opsum_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SEND_FILTER;
          first_n = 1'b1;
          cnt_n   = '0;
          col_n   = '0;
          vld_n   = 1'b0;
        end
      end
      SEND_FILTER, SEND_IFMAP, SEND_IPSUM: begin
        rd_en = first | (hs & ~last);
        if (first) vld_n = 1'b1;
        if (hs) begin
          if (last) begin
            cnt_n = '0;
            vld_n = 1'b0;
            if (state == SEND_FILTER) begin
              state_n = SEND_IFMAP;
              first_n = 1'b1;
            end else if (state == SEND_IFMAP) begin
              state_n = SEND_IPSUM;
              first_n = 1'b1;
            end else begin
              state_n = RECV_OPSUM;
            end
          end else begin
            cnt_n = cnt + 5'd1;
          end
        end
      end
      RECV_OPSUM: begin
        opsum_ready = 1'b1;
        if (opsum_valid) begin
          wr_en = 1'b1;
          if (last) begin
            cnt_n = '0;
            if (col == cfg_q[6:2]) begin
              state_n = IDLE;
              done    = 1'b1;
            end else begin
              col_n   = col + 5'd1;
              state_n = SEND_IFMAP;
              first_n = 1'b1;
            end
          end else begin
            cnt_n = cnt + 5'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      col     <= '0;
      first   <= 1'b0;
      vld     <= 1'b0;
      pe_en_q <= 1'b0;
      cfg_q   <= '0;
      fb_q    <= '0;
      ib_q    <= '0;
      pb_q    <= '0;
      ob_q    <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      col     <= col_n;
      first   <= first_n;
      vld     <= vld_n;
      pe_en_q <= accept;
      if (accept) begin
        cfg_q <= cfg;
        fb_q  <= filter_base;
        ib_q  <= ifmap_base;
        pb_q  <= ipsum_base;
        ob_q  <= opsum_base;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign pe_en     = pe_en_q;
  assign pe_config = cfg_q;

  assign filter_valid = vld && (state == SEND_FILTER);
  assign ifmap_valid  = vld && (state == SEND_IFMAP);
  assign ipsum_valid  = vld && (state == SEND_IPSUM);

  assign filter = filter_valid ? rd_data : '0;
  assign ifmap  = ifmap_valid  ? rd_data : '0;
  assign ipsum  = ipsum_valid  ? rd_data : '0;

  assign rd_addr = rd_en ? rd_base + ADDR_BITS'(rd_off) : '0;
  assign wr_addr = wr_en ? ob_q + ADDR_BITS'(wr_off) : '0;
  assign wr_data = wr_en ? opsum : '0;

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: table of jobs run against a buffer model, plus
// hand-written reset and stall sequences.
module tb_pe_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [12:0] cfg;
  logic [15:0] filter_base, ifmap_base, ipsum_base, opsum_base;
  logic        busy, done, rd_en, wr_en, pe_en;
  logic [15:0] rd_addr, wr_addr;
  logic [31:0] rd_data, wr_data;
  logic [12:0] pe_config;
  logic [31:0] filter, ifmap, ipsum, opsum;
  logic        filter_valid, ifmap_valid, ipsum_valid;
  logic        filter_ready, ifmap_ready, ipsum_ready;
  logic        opsum_valid, opsum_ready;

  pe_feeder dut (
    .clk(clk), .rst(rst), .start(start), .cfg(cfg),
    .filter_base(filter_base), .ifmap_base(ifmap_base),
    .ipsum_base(ipsum_base), .opsum_base(opsum_base),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pe_en(pe_en), .pe_config(pe_config),
    .filter(filter), .ifmap(ifmap), .ipsum(ipsum),
    .filter_valid(filter_valid), .ifmap_valid(ifmap_valid),
    .ipsum_valid(ipsum_valid),
    .filter_ready(filter_ready), .ifmap_ready(ifmap_ready),
    .ipsum_ready(ipsum_ready),
    .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready)
  );

  always #5 clk = ~clk;

  // Buffer model: each word encodes its own address.
  always @(posedge clk) if (rd_en) rd_data <= {16'h5A00, rd_addr};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [12:0] cfg;
    logic        stall;
    logic        poke;
    logic [15:0] fb, ib, pb, ob;
    int          nf, ni, np, no;
  } job_t;

  job_t jobs[6];

  logic [31:0] qf[$], qi[$], qp[$];
  logic [15:0] qo[$];
  logic [31:0] ef[$], ei[$], ep[$];
  logic [15:0] eo[$];

  task automatic gen_exp(input job_t j);
    int pp, qq, rr, nc, nn;
    logic [15:0] a;
    pp = int'(j.cfg[8:7]) + 1;
    qq = int'(j.cfg[1:0]) + 1;
    rr = int'(j.cfg[11:10]) + 1;
    nc = int'(j.cfg[6:2]) + 1;
    nn = j.cfg[12] ? qq : pp;
    ef.delete(); ei.delete(); ep.delete(); eo.delete();
    for (int k = 0; k < pp * rr; k++) begin
      a = j.fb + 16'(k);
      ef.push_back({16'h5A00, a});
    end
    for (int c = 0; c < nc; c++) begin
      if (c == 0) begin
        for (int k = 0; k < rr; k++) begin
          a = j.ib + 16'(k);
          ei.push_back({16'h5A00, a});
        end
      end else begin
        a = j.ib + 16'(rr - 1 + c);
        ei.push_back({16'h5A00, a});
      end
      for (int k = 0; k < nn; k++) begin
        a = j.pb + 16'(c * nn + k);
        ep.push_back({16'h5A00, a});
        a = j.ob + 16'(c * nn + k);
        eo.push_back(a);
      end
    end
  endtask

  task automatic drive(input logic stall);
    if (stall) begin
      filter_ready = ($urandom_range(0, 2) != 0);
      ifmap_ready  = ($urandom_range(0, 2) != 0);
      ipsum_ready  = ($urandom_range(0, 2) != 0);
      opsum_valid  = ($urandom_range(0, 2) != 0);
    end else begin
      filter_ready = 1'b1;
      ifmap_ready  = 1'b1;
      ipsum_ready  = 1'b1;
      opsum_valid  = 1'b1;
    end
  endtask

  task automatic run_job(input job_t j);
    int hold_sel, owc, extra_pe, nv;
    logic [31:0] hold_data, cur;
    logic cv, got_done;
    qf.delete(); qi.delete(); qp.delete(); qo.delete();
    gen_exp(j);
    hold_sel = 0; owc = 0; extra_pe = 0; got_done = 1'b0;
    opsum = 32'hF00D_0000;
    cfg = j.cfg;
    filter_base = j.fb; ifmap_base = j.ib;
    ipsum_base = j.pb; opsum_base = j.ob;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      start = (j.poke && (c == 3 || c == 4));
      drive(j.stall);
      #1;
      if (c == 0) begin
        chk("pe_en", 32'(pe_en), 32'd1);
        chk("pe_config", 32'(pe_config), 32'(j.cfg));
        chk("busy_start", 32'(busy), 32'd1);
      end else if (pe_en) begin
        extra_pe++;
      end
      nv = int'(filter_valid) + int'(ifmap_valid) + int'(ipsum_valid);
      chk("onehot", 32'(nv <= 1), 32'd1);
      if (hold_sel != 0) begin
        cv  = (hold_sel == 1) ? filter_valid
            : (hold_sel == 2) ? ifmap_valid : ipsum_valid;
        cur = (hold_sel == 1) ? filter
            : (hold_sel == 2) ? ifmap : ipsum;
        chk("stall_valid", 32'(cv), 32'd1);
        chk("stall_data", cur, hold_data);
        hold_sel = 0;
      end
      if (filter_valid && !filter_ready) begin
        hold_sel = 1; hold_data = filter;
      end
      if (ifmap_valid && !ifmap_ready) begin
        hold_sel = 2; hold_data = ifmap;
      end
      if (ipsum_valid && !ipsum_ready) begin
        hold_sel = 3; hold_data = ipsum;
      end
      if (filter_valid && filter_ready) qf.push_back(filter);
      if (ifmap_valid && ifmap_ready) qi.push_back(ifmap);
      if (ipsum_valid && ipsum_ready) qp.push_back(ipsum);
      if (wr_en) begin
        chk("wr_hs", 32'(opsum_valid && opsum_ready), 32'd1);
        chk("wr_data", wr_data, opsum);
        qo.push_back(wr_addr);
        owc++;
        opsum = 32'hF00D_0000 | 32'(owc);
      end
      if (done) begin
        chk("done_busy", 32'(busy), 32'd1);
        got_done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("job_done", 32'(got_done), 32'd1);
    chk("extra_pe_en", 32'(extra_pe), 32'd0);
    chk("n_filter", 32'(qf.size()), 32'(j.nf));
    chk("n_ifmap", 32'(qi.size()), 32'(j.ni));
    chk("n_ipsum", 32'(qp.size()), 32'(j.np));
    chk("n_opsum", 32'(qo.size()), 32'(j.no));
    for (int i = 0; i < qf.size() && i < ef.size(); i++)
      chk("filter_word", qf[i], ef[i]);
    for (int i = 0; i < qi.size() && i < ei.size(); i++)
      chk("ifmap_word", qi[i], ei[i]);
    for (int i = 0; i < qp.size() && i < ep.size(); i++)
      chk("ipsum_word", qp[i], ep[i]);
    for (int i = 0; i < qo.size() && i < eo.size(); i++)
      chk("opsum_addr", 32'(qo[i]), 32'(eo[i]));
    @(negedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_ctl"},
        32'({busy, done, rd_en, wr_en, pe_en, filter_valid,
             ifmap_valid, ipsum_valid, opsum_ready}), 32'd0);
    chk({name, "_addr"}, {rd_addr, wr_addr}, 32'd0);
    chk({name, "_cfg"}, 32'(pe_config), 32'd0);
    chk({name, "_data"}, filter | ifmap | ipsum | wr_data, 32'd0);
  endtask

  initial begin
    // cfg, stall, poke, bases, expected word counts f/i/p/o
    jobs[0] = '{13'h0882, 1'b0, 1'b0, 16'h0100, 16'h0200,
                16'h0300, 16'h0400, 6, 3, 2, 2};
    jobs[1] = '{13'h0A88, 1'b0, 1'b0, 16'h1000, 16'h2000,
                16'h3000, 16'h4000, 6, 5, 6, 6};
    jobs[2] = '{13'h1407, 1'b0, 1'b0, 16'h0010, 16'h0020,
                16'h0030, 16'h0040, 2, 3, 8, 8};
    jobs[3] = '{13'h0A88, 1'b1, 1'b0, 16'h1000, 16'h2000,
                16'h3000, 16'h4000, 6, 5, 6, 6};
    jobs[4] = '{13'h0882, 1'b0, 1'b1, 16'h0500, 16'h0600,
                16'h0700, 16'h0800, 6, 3, 2, 2};
    jobs[5] = '{13'h0D8C, 1'b1, 1'b0, 16'hFFFA, 16'hFFFE,
                16'hFFF5, 16'hFFF8, 16, 7, 16, 16};

    rst = 1'b1; start = 1'b0; cfg = '0; opsum = '0;
    filter_base = '0; ifmap_base = '0;
    ipsum_base = '0; opsum_base = '0;
    drive(1'b0);
    #1;
    chk_quiet("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_job(jobs[i]);

    // Abort a job in SEND_IPSUM, then relaunch.
    cfg = jobs[1].cfg;
    filter_base = 16'h0A00; ifmap_base = 16'h0B00;
    ipsum_base = 16'h0C00; opsum_base = 16'h0D00;
    drive(1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        #1;
        if (ipsum_valid) seen = 1'b1;
        else @(negedge clk);
      end
      chk("reach_ipsum", 32'(seen), 32'd1);
    end
    rst = 1'b1;
    #1;
    chk_quiet("midrst");
    @(negedge clk);
    #1;
    chk_quiet("midrst_hold");
    @(negedge clk);
    rst = 1'b0;
    run_job(jobs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
